instr_encoder_loader: RTL and testbench
=======================================

// Module: instr_encoder_loader
// PURPOSE
// - Inverse of the instruction decoder: accepts decoded RV32I fields over valid/ready,
//   packs them into 32-bit instruction words and streams them into instruction memory.
// - Sits between the debug/boot host interface and the imem write port.
// - Round-trip contract: decoding the written word yields the same opcode, funct, reg and imm fields.
// PARAMETERS
// - BASE_ADDR    32'h0000_0000  byte address of first written word
// - DEPTH_WORDS  1024           imem capacity in words; a write beyond it is an overflow
// PORTS
// - clk            in   1   single clock, rising edge
// - reset          in   1   synchronous, active-high
// - in_valid       in   1   field tuple valid
// - in_ready       out  1   block can accept a tuple this cycle
// - in_opcode      in   7   instr[6:0]
// - in_funct3      in   3   instr[14:12]
// - in_funct7      in   7   instr[31:25] (R-type, shift-immediates)
// - in_rd/in_rs1/in_rs2 in 5 each  register indices
// - in_imm         in   32  sign-extended immediate, same layout the decoder emits
// - in_last        in   1   tuple is the final word of the program
// - mem_addr       out  32  byte address, word aligned
// - mem_wdata      out  32  encoded instruction
// - mem_we         out  1   write request; held with addr/data stable until mem_ack
// - mem_ack        in   1   write accepted this cycle
// - words_written  out  $clog2(DEPTH_WORDS)+1  count of acked writes
// - done           out  1   sticky: in_last word acked
// - error          out  1   sticky: bad opcode, immediate out of range, or overflow
// BEHAVIOUR
// - Reset: state=IDLE, in_ready=1, mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0, counters/flags=0.
// - FSM IDLE -> ENC -> WRITE -> IDLE | DONE; any state -> ERROR on a check failure.
//   IDLE: in_ready=1; handshake in_valid&in_ready captures all fields -> ENC.
//   ENC: pack + check (1 cycle); pass -> WRITE with mem_wdata registered; fail -> ERROR.
//   WRITE: mem_we=1 until mem_ack; on ack: words_written+1, mem_addr+4, -> DONE if last else IDLE.
//   DONE/ERROR: in_ready=0, mem_we=0; left only by reset.
// - Latency: tuple accepted cycle N -> mem_we first high cycle N+2; ack same cycle -> in_ready high N+3.
//   Peak throughput one word per 3 cycles; no internal buffering.
// - Formats (opcode): U 0?10111, J 1101111, I 1100111/0000011/0010011, B 1100011, S 0100011, R 0110011.
// - Checks (fail -> error): I/S imm[31:11] all equal; B imm[0]=0 and imm[31:12] all equal;
//   J imm[0]=0 and imm[31:20] all equal; U imm[11:0]=0; OP-IMM funct3 001/101: imm[11:5]=0,
//   word[31:25]=in_funct7; FENCE 0001111 and any other opcode rejected, matching the decoder.
// - Overflow: tuple accepted when words_written==DEPTH_WORDS -> ERROR in ENC, no write.
// - mem_addr wraps never; overflow fires first. Fields of R-type imm ignored.
// - mem_ack outside WRITE ignored. Reset during WRITE: mem_we low next cycle, write abandoned.
// STRUCTURE
// - Shared package riscv_defs: opcode localparams, format enum {FMT_R,I,S,B,U,J,BAD}, funct3 shift codes.
// - Sub-module instr_field_packer: combinational fields -> {word, fmt, range_ok}; this block holds
//   the FSM, capture registers, address/counter and handshakes.
// TESTING
// - ADDI x1,x0,-1 (0010011,f3=0,rd=1,imm=32'hFFFF_FFFF), mem_ack tied 1 -> word 32'hFFF0_0093 at addr 0, mem_we on cycle N+2.
// - JAL x0,-4 then BEQ x1,x2,+8 with in_last -> words 32'hFFDF_F06F @0, 32'h0020_8463 @4; done=1, in_ready=0.
// - SW x5,12(x2) with mem_ack delayed 5 cycles -> 32'h0051_2623 held stable, mem_we high exactly until ack.
// - ADDI imm=32'h0000_0800 -> error=1, no mem_we; also opcode 0001111 -> error=1.
// - DEPTH_WORDS=2, three tuples -> two writes, third sets error, words_written=2.
// - Reset asserted during WRITE -> mem_we=0, mem_addr=BASE_ADDR, words_written=0 next cycle; new tuple written at BASE_ADDR.

Source files
------------

// File: rtl/riscv_defs.sv
// RV32I encoding constants shared by the encoder/loader and its field packer.
// Also holds opcode-to-format classification and the immediate range helper.
package riscv_defs;

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_FENCE  = 7'b0001111;

   localparam logic [2:0] F3_SLL = 3'b001;
   localparam logic [2:0] F3_SRX = 3'b101;

   typedef enum logic [2:0] {
      FMT_R   = 3'd0,
      FMT_I   = 3'd1,
      FMT_S   = 3'd2,
      FMT_B   = 3'd3,
      FMT_U   = 3'd4,
      FMT_J   = 3'd5,
      FMT_BAD = 3'd6
   } fmt_t;

   // FENCE is deliberately unsupported so the round trip matches the decoder.
   function automatic fmt_t opcode_fmt(input logic [6:0] op);
      fmt_t f;
      case (op)
         OPC_LUI, OPC_AUIPC:            f = FMT_U;
         OPC_JAL:                       f = FMT_J;
         OPC_JALR, OPC_LOAD, OPC_OP_IMM: f = FMT_I;
         OPC_BRANCH:                    f = FMT_B;
         OPC_STORE:                     f = FMT_S;
         OPC_OP:                        f = FMT_R;
         default:                       f = FMT_BAD;
      endcase
      return f;
   endfunction

   // True when imm[31:lsb] are all copies of one bit, i.e. a clean sign extension.
   function automatic logic sext_ok(input logic [31:0] imm, input logic [4:0] lsb);
      logic [31:0] sh;
      sh = 32'($signed(imm) >>> lsb);
      return (sh == 32'h0000_0000) || (sh == 32'hFFFF_FFFF);
   endfunction

endpackage

// File: rtl/instr_field_packer.sv
// Combinational RV32I field packer: decoded fields in, instruction word out,
// plus the format and a flag saying the immediate fits the encoding.
module instr_field_packer
   import riscv_defs::*;
(
   input  logic [6:0]  opcode,
   input  logic [2:0]  funct3,
   input  logic [6:0]  funct7,
   input  logic [4:0]  rd,
   input  logic [4:0]  rs1,
   input  logic [4:0]  rs2,
   input  logic [31:0] imm,
   output logic [31:0] word,
   output fmt_t        fmt,
   output logic        range_ok
);

   logic shift_imm_s;

   assign shift_imm_s = (opcode == OPC_OP_IMM) &&
                        ((funct3 == F3_SLL) || (funct3 == F3_SRX));

   // Pack the fields into the instruction layout selected by the opcode.
   always_comb begin
      word     = 32'h0000_0000;
      range_ok = 1'b0;
      fmt      = opcode_fmt(opcode);
      case (fmt)
         FMT_R: begin
            word     = {funct7, rs2, rs1, funct3, rd, opcode};
            range_ok = 1'b1;
         end
         FMT_I: begin
            if (shift_imm_s) begin
               // Shift-immediates carry funct7 in the upper bits, shamt in imm[4:0].
               word     = {funct7, imm[4:0], rs1, funct3, rd, opcode};
               range_ok = (imm[11:5] == 7'h00) && sext_ok(imm, 5'd11);
            end else begin
               word     = {imm[11:0], rs1, funct3, rd, opcode};
               range_ok = sext_ok(imm, 5'd11);
            end
         end
         FMT_S: begin
            word     = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
            range_ok = sext_ok(imm, 5'd11);
         end
         FMT_B: begin
            word     = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
            range_ok = (imm[0] == 1'b0) && sext_ok(imm, 5'd12);
         end
         FMT_U: begin
            word     = {imm[31:12], rd, opcode};
            range_ok = (imm[11:0] == 12'h000);
         end
         FMT_J: begin
            word     = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
            range_ok = (imm[0] == 1'b0) && sext_ok(imm, 5'd20);
         end
         default: begin
            word     = 32'h0000_0000;
            range_ok = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/instr_encoder_loader.sv
// Accepts decoded RV32I field tuples, encodes them and streams the words into
// instruction memory, one held write per tuple, with sticky done/error flags.
module instr_encoder_loader
   import riscv_defs::*;
#(
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
   parameter int          DEPTH_WORDS = 1024
)(
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           in_valid,
   output logic                           in_ready,
   input  logic [6:0]                     in_opcode,
   input  logic [2:0]                     in_funct3,
   input  logic [6:0]                     in_funct7,
   input  logic [4:0]                     in_rd,
   input  logic [4:0]                     in_rs1,
   input  logic [4:0]                     in_rs2,
   input  logic [31:0]                    in_imm,
   input  logic                           in_last,
   output logic [31:0]                    mem_addr,
   output logic [31:0]                    mem_wdata,
   output logic                           mem_we,
   input  logic                           mem_ack,
   output logic [$clog2(DEPTH_WORDS):0]   words_written,
   output logic                           done,
   output logic                           error
);

   localparam int CW = $clog2(DEPTH_WORDS) + 1;
   localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH_WORDS);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_ENC   = 3'd1;
   localparam logic [2:0] S_WRITE = 3'd2;
   localparam logic [2:0] S_DONE  = 3'd3;
   localparam logic [2:0] S_ERROR = 3'd4;

   logic [2:0]    state_r;
   logic [6:0]    opcode_r;
   logic [2:0]    funct3_r;
   logic [6:0]    funct7_r;
   logic [4:0]    rd_r;
   logic [4:0]    rs1_r;
   logic [4:0]    rs2_r;
   logic [31:0]   imm_r;
   logic          last_r;
   logic          in_ready_r;
   logic [31:0]   mem_addr_r;
   logic [31:0]   mem_wdata_r;
   logic          mem_we_r;
   logic [CW-1:0] words_written_r;
   logic          done_r;
   logic          error_r;

   logic [31:0]   word_s;
   fmt_t          fmt_s;
   logic          range_ok_s;
   logic          enc_ok_s;

   instr_field_packer u_packer (
      .opcode   (opcode_r),
      .funct3   (funct3_r),
      .funct7   (funct7_r),
      .rd       (rd_r),
      .rs1      (rs1_r),
      .rs2      (rs2_r),
      .imm      (imm_r),
      .word     (word_s),
      .fmt      (fmt_s),
      .range_ok (range_ok_s)
   );

   // A full memory is reported as an error before any write is attempted.
   assign enc_ok_s = range_ok_s && (fmt_s != FMT_BAD) && (words_written_r != DEPTH_CNT);

   // Main FSM with capture registers, write address and word counter.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r         <= S_IDLE;
         opcode_r        <= 7'h00;
         funct3_r        <= 3'h0;
         funct7_r        <= 7'h00;
         rd_r            <= 5'h00;
         rs1_r           <= 5'h00;
         rs2_r           <= 5'h00;
         imm_r           <= 32'h0000_0000;
         last_r          <= 1'b0;
         in_ready_r      <= 1'b1;
         mem_addr_r      <= BASE_ADDR;
         mem_wdata_r     <= 32'h0000_0000;
         mem_we_r        <= 1'b0;
         words_written_r <= '0;
         done_r          <= 1'b0;
         error_r         <= 1'b0;
      end else begin
         case (state_r)
            S_IDLE: begin
               if (in_valid && in_ready_r) begin
                  opcode_r   <= in_opcode;
                  funct3_r   <= in_funct3;
                  funct7_r   <= in_funct7;
                  rd_r       <= in_rd;
                  rs1_r      <= in_rs1;
                  rs2_r      <= in_rs2;
                  imm_r      <= in_imm;
                  last_r     <= in_last;
                  in_ready_r <= 1'b0;
                  state_r    <= S_ENC;
               end
            end
            S_ENC: begin
               if (enc_ok_s) begin
                  mem_wdata_r <= word_s;
                  mem_we_r    <= 1'b1;
                  state_r     <= S_WRITE;
               end else begin
                  error_r <= 1'b1;
                  state_r <= S_ERROR;
               end
            end
            S_WRITE: begin
               if (mem_ack) begin
                  mem_we_r        <= 1'b0;
                  words_written_r <= words_written_r + CW'(1);
                  mem_addr_r      <= mem_addr_r + 32'd4;
                  if (last_r) begin
                     done_r  <= 1'b1;
                     state_r <= S_DONE;
                  end else begin
                     in_ready_r <= 1'b1;
                     state_r    <= S_IDLE;
                  end
               end
            end
            S_DONE, S_ERROR: begin
               in_ready_r <= 1'b0;
               mem_we_r   <= 1'b0;
            end
            default: begin
               in_ready_r <= 1'b0;
               mem_we_r   <= 1'b0;
               error_r    <= 1'b1;
               state_r    <= S_ERROR;
            end
         endcase
      end
   end

   assign in_ready      = in_ready_r;
   assign mem_addr      = mem_addr_r;
   assign mem_wdata     = mem_wdata_r;
   assign mem_we        = mem_we_r;
   assign words_written = words_written_r;
   assign done          = done_r;
   assign error         = error_r;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed bench: a default-depth loader plus a two-word loader for overflow,
// expected words hand-encoded from the RV32I formats.
module tb_instr_encoder_loader;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [6:0]  in_opcode = 7'h00;
   logic [2:0]  in_funct3 = 3'h0;
   logic [6:0]  in_funct7 = 7'h00;
   logic [4:0]  in_rd = 5'h00;
   logic [4:0]  in_rs1 = 5'h00;
   logic [4:0]  in_rs2 = 5'h00;
   logic [31:0] in_imm = 32'h0;
   logic        in_last = 1'b0;

   logic        valid_a = 1'b0;
   logic        ack_a = 1'b0;
   logic        ready_a;
   logic [31:0] addr_a;
   logic [31:0] wdata_a;
   logic        we_a;
   logic [10:0] words_a;
   logic        done_a;
   logic        error_a;

   logic        valid_b = 1'b0;
   logic        ack_b = 1'b0;
   logic        ready_b;
   logic [31:0] addr_b;
   logic [31:0] wdata_b;
   logic        we_b;
   logic [1:0]  words_b;
   logic        done_b;
   logic        error_b;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   instr_encoder_loader dut_a (
      .clk(clk), .reset(reset), .in_valid(valid_a), .in_ready(ready_a),
      .in_opcode(in_opcode), .in_funct3(in_funct3), .in_funct7(in_funct7),
      .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
      .in_last(in_last), .mem_addr(addr_a), .mem_wdata(wdata_a), .mem_we(we_a),
      .mem_ack(ack_a), .words_written(words_a), .done(done_a), .error(error_a)
   );

   instr_encoder_loader #(.BASE_ADDR(32'h0000_0000), .DEPTH_WORDS(2)) dut_b (
      .clk(clk), .reset(reset), .in_valid(valid_b), .in_ready(ready_b),
      .in_opcode(in_opcode), .in_funct3(in_funct3), .in_funct7(in_funct7),
      .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
      .in_last(in_last), .mem_addr(addr_b), .mem_wdata(wdata_b), .mem_we(we_b),
      .mem_ack(ack_b), .words_written(words_b), .done(done_b), .error(error_b)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic apply_reset();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
   endtask

   task automatic set_tuple(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                            input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                            input logic [31:0] imm, input logic last);
      in_opcode = op; in_funct3 = f3; in_funct7 = f7;
      in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm; in_last = last;
   endtask

   // Offers the tuple for one cycle; returns in the cycle after acceptance.
   task automatic send_a();
      valid_a = 1'b1;
      tick();
      valid_a = 1'b0;
   endtask

   task automatic send_b();
      valid_b = 1'b1;
      tick();
      valid_b = 1'b0;
   endtask

   initial begin
      apply_reset();
      chk("rst_ready", 32'(ready_a), 32'd1);
      chk("rst_we", 32'(we_a), 32'd0);
      chk("rst_addr", addr_a, 32'h0000_0000);
      chk("rst_wdata", wdata_a, 32'h0000_0000);
      chk("rst_words", 32'(words_a), 32'd0);
      chk("rst_done", 32'(done_a), 32'd0);
      chk("rst_error", 32'(error_a), 32'd0);

      // ADDI x1,x0,-1 with ack tied high
      ack_a = 1'b1;
      set_tuple(7'b0010011, 3'b000, 7'h00, 5'd1, 5'd0, 5'd0, 32'hFFFF_FFFF, 1'b0);
      send_a();
      chk("addi_we_n1", 32'(we_a), 32'd0);
      tick();
      chk("addi_we_n2", 32'(we_a), 32'd1);
      chk("addi_word", wdata_a, 32'hFFF0_0093);
      chk("addi_addr", addr_a, 32'h0000_0000);
      tick();
      chk("addi_ready_n3", 32'(ready_a), 32'd1);
      chk("addi_we_n3", 32'(we_a), 32'd0);
      chk("addi_words", 32'(words_a), 32'd1);
      chk("addi_next_addr", addr_a, 32'h0000_0004);
      tick();
      chk("idle_ack_ignored", 32'(words_a), 32'd1);

      // JAL x0,-4 then BEQ x1,x2,+8 marked last
      apply_reset();
      set_tuple(7'b1101111, 3'b000, 7'h00, 5'd0, 5'd0, 5'd0, 32'hFFFF_FFFC, 1'b0);
      send_a();
      tick();
      chk("jal_word", wdata_a, 32'hFFDF_F06F);
      chk("jal_addr", addr_a, 32'h0000_0000);
      tick();
      set_tuple(7'b1100011, 3'b000, 7'h00, 5'd0, 5'd1, 5'd2, 32'h0000_0008, 1'b1);
      send_a();
      tick();
      chk("beq_word", wdata_a, 32'h0020_8463);
      chk("beq_addr", addr_a, 32'h0000_0004);
      tick();
      chk("beq_done", 32'(done_a), 32'd1);
      chk("beq_ready", 32'(ready_a), 32'd0);
      chk("beq_words", 32'(words_a), 32'd2);
      chk("beq_we_off", 32'(we_a), 32'd0);

      // SW x5,12(x2) with a late ack
      apply_reset();
      ack_a = 1'b0;
      set_tuple(7'b0100011, 3'b010, 7'h00, 5'd0, 5'd2, 5'd5, 32'h0000_000C, 1'b0);
      send_a();
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("sw_we_held", 32'(we_a), 32'd1);
         chk("sw_word_held", wdata_a, 32'h0051_2623);
         if (i == 4) ack_a = 1'b1;
      end
      tick();
      ack_a = 1'b0;
      chk("sw_we_drop", 32'(we_a), 32'd0);
      chk("sw_words", 32'(words_a), 32'd1);
      chk("sw_ready", 32'(ready_a), 32'd1);

      // ADDI immediate out of 12-bit range
      apply_reset();
      ack_a = 1'b1;
      set_tuple(7'b0010011, 3'b000, 7'h00, 5'd1, 5'd0, 5'd0, 32'h0000_0800, 1'b0);
      send_a();
      tick();
      chk("range_error", 32'(error_a), 32'd1);
      chk("range_no_we", 32'(we_a), 32'd0);
      chk("range_ready", 32'(ready_a), 32'd0);

      // FENCE is rejected
      apply_reset();
      set_tuple(7'b0001111, 3'b000, 7'h00, 5'd0, 5'd0, 5'd0, 32'h0000_0000, 1'b0);
      send_a();
      tick();
      chk("fence_error", 32'(error_a), 32'd1);
      chk("fence_no_we", 32'(we_a), 32'd0);

      // Overflow on the two-word instance
      apply_reset();
      ack_b = 1'b1;
      set_tuple(7'b0010011, 3'b000, 7'h00, 5'd1, 5'd0, 5'd0, 32'h0000_0005, 1'b0);
      send_b();
      tick();
      tick();
      send_b();
      tick();
      chk("ovf_second_addr", addr_b, 32'h0000_0004);
      chk("ovf_second_word", wdata_b, 32'h0050_0093);
      tick();
      chk("ovf_words_2", 32'(words_b), 32'd2);
      send_b();
      tick();
      chk("ovf_error", 32'(error_b), 32'd1);
      chk("ovf_no_we", 32'(we_b), 32'd0);
      chk("ovf_words_kept", 32'(words_b), 32'd2);
      ack_b = 1'b0;

      // Reset in the middle of a held write
      apply_reset();
      ack_a = 1'b1;
      set_tuple(7'b0010011, 3'b000, 7'h00, 5'd1, 5'd0, 5'd0, 32'hFFFF_FFFF, 1'b0);
      send_a();
      tick();
      tick();
      ack_a = 1'b0;
      send_a();
      tick();
      chk("rstw_we_before", 32'(we_a), 32'd1);
      reset = 1'b1;
      tick();
      chk("rstw_we", 32'(we_a), 32'd0);
      chk("rstw_addr", addr_a, 32'h0000_0000);
      chk("rstw_words", 32'(words_a), 32'd0);
      reset = 1'b0;
      ack_a = 1'b1;
      set_tuple(7'b0110011, 3'b000, 7'b0100000, 5'd3, 5'd1, 5'd2, 32'h0000_0000, 1'b0);
      send_a();
      tick();
      chk("rstw_new_addr", addr_a, 32'h0000_0000);
      chk("rstw_new_word", wdata_a, 32'h4020_81B3);
      chk("rstw_new_we", 32'(we_a), 32'd1);
      tick();
      ack_a = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
